// File: rtl/full_adder_checker.sv
// full_adder_checker: response checker for a full-adder under test.
// Each accepted vector {A,B,C} is latched. The observed Sum/Carry are sampled
// SETTLE_CYCLES edges later and compared against the golden result.
// The checker counts mismatches, tracks which of the 8 input combinations
// have been exercised, and reports pass/fail once all 8 have been checked.
// SETTLE_CYCLES must lie in 1..15 so it fits the 4-bit settle counter.
module full_adder_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 sample_valid,
    input  logic                 Data_in_A,
    input  logic                 Data_in_B,
    input  logic                 Data_in_C,
    input  logic                 Data_in_Sum,
    input  logic                 Data_in_Carry,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] error_count,
    output logic [3:0]           vectors_seen,
    output logic [7:0]           coverage,
    output logic [2:0]           first_err_vec,
    output logic                 first_err_valid,
    output logic                 overrun
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t     state;
    logic [2:0] vec;        // latched {A,B,C} of the in-flight check
    logic [3:0] settle_cnt; // edges left before the outputs are sampled

    logic       exp_sum;
    logic       exp_carry;
    logic       mismatch;
    logic [7:0] cov_next;

    // Golden full-adder result for the latched vector, and the coverage it produces
    always_comb begin
        exp_sum   = vec[2] ^ vec[1] ^ vec[0];
        exp_carry = (vec[2] & vec[1]) | (vec[0] & (vec[2] ^ vec[1]));
        mismatch  = (Data_in_Sum != exp_sum) || (Data_in_Carry != exp_carry);
        cov_next  = coverage | (8'b1 << vec);
    end

    // pass is only meaningful once the run has completed
    assign pass = done && (error_count == '0);

    // Checker FSM with registered status and result outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            vec             <= '0;
            settle_cnt      <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            error_count     <= '0;
            vectors_seen    <= '0;
            coverage        <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
            overrun         <= 1'b0;
        end else begin
            case (state)
                // A new run may start from idle or after a finished run;
                // a sample arriving alongside start is not captured.
                IDLE, DONE: begin
                    if (start) begin
                        state           <= ARMED;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        error_count     <= '0;
                        vectors_seen    <= '0;
                        coverage        <= '0;
                        first_err_vec   <= '0;
                        first_err_valid <= 1'b0;
                        overrun         <= 1'b0;
                    end
                end

                ARMED: begin
                    if (sample_valid) begin
                        vec        <= {Data_in_A, Data_in_B, Data_in_C};
                        settle_cnt <= 4'(SETTLE_CYCLES - 1);
                        state      <= SETTLE;
                    end
                end

                SETTLE: begin
                    // A vector offered while one is in flight is dropped.
                    // The in-flight check proceeds unchanged.
                    if (sample_valid)
                        overrun <= 1'b1;
                    if (settle_cnt != 4'd0) begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end else begin
                        if (vectors_seen != 4'hF)
                            vectors_seen <= vectors_seen + 4'd1;
                        coverage <= cov_next;
                        if (mismatch) begin
                            if (error_count != '1)
                                error_count <= error_count + 1'b1;
                            if (!first_err_valid) begin
                                first_err_vec   <= vec;
                                first_err_valid <= 1'b1;
                            end
                        end
                        if (cov_next == 8'hFF) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ARMED;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_full_adder_checker.sv
// Bench for full_adder_checker.
// Two instances share all inputs: one with an 8-bit error counter and one
// with a 2-bit error counter, so saturation is observable.
// A cycle-level reference model is compared against both instances on every
// cycle, and scenario-end checks use hand-computed literal values.
module tb_full_adder_checker;

    localparam int S = 2;

    logic clk = 1'b0;
    logic reset, start, sample_valid, a, b, c, sum_in, carry_in;

    logic       busy0, done0, pass0, fevv0, ovr0;
    logic [7:0] err0, cov0;
    logic [3:0] vs0;
    logic [2:0] fev0;

    logic       busy1, done1, pass1, fevv1, ovr1;
    logic [1:0] err1;
    logic [7:0] cov1;
    logic [3:0] vs1;
    logic [2:0] fev1;

    int n_chk  = 0;
    int n_pass = 0;

    full_adder_checker #(.SETTLE_CYCLES(S), .ERR_CNT_W(8)) dut0 (
        .clk(clk), .reset(reset), .start(start), .sample_valid(sample_valid),
        .Data_in_A(a), .Data_in_B(b), .Data_in_C(c),
        .Data_in_Sum(sum_in), .Data_in_Carry(carry_in),
        .busy(busy0), .done(done0), .pass(pass0), .error_count(err0),
        .vectors_seen(vs0), .coverage(cov0), .first_err_vec(fev0),
        .first_err_valid(fevv0), .overrun(ovr0));

    full_adder_checker #(.SETTLE_CYCLES(S), .ERR_CNT_W(2)) dut1 (
        .clk(clk), .reset(reset), .start(start), .sample_valid(sample_valid),
        .Data_in_A(a), .Data_in_B(b), .Data_in_C(c),
        .Data_in_Sum(sum_in), .Data_in_Carry(carry_in),
        .busy(busy1), .done(done1), .pass(pass1), .error_count(err1),
        .vectors_seen(vs1), .coverage(cov1), .first_err_vec(fev1),
        .first_err_valid(fevv1), .overrun(ovr1));

    always #5 clk = ~clk;

    function automatic int imin(input int x, input int y);
        return (x < y) ? x : y;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Reference model. Mode: 0 idle, 1 waiting for a vector,
    // 2 vector in flight, 3 run complete.
    // The raw counts are unbounded; saturation is applied at compare time.
    int         cyc = 0;
    int         m_mode = 0;
    int         m_due = 0;
    logic [2:0] m_vec = '0;
    int         m_nerr = 0;
    int         m_nvec = 0;
    logic [7:0] m_cov = '0;
    logic [2:0] m_fev = '0;
    logic       m_fevv = 1'b0;
    logic       m_ovr = 1'b0;

    always @(posedge clk) begin : model
        int         s;
        logic       bad;
        logic [7:0] nc;
        s   = int'(m_vec[2]) + int'(m_vec[1]) + int'(m_vec[0]);
        bad = (sum_in !== s[0]) || (carry_in !== s[1]);
        nc  = m_cov | (8'd1 << m_vec);
        cyc <= cyc + 1;
        if (reset) begin
            m_mode <= 0; m_nerr <= 0; m_nvec <= 0; m_cov <= '0;
            m_fev <= '0; m_fevv <= 1'b0; m_ovr <= 1'b0;
        end else begin
            case (m_mode)
                0, 3: if (start) begin
                    m_mode <= 1; m_nerr <= 0; m_nvec <= 0; m_cov <= '0;
                    m_fev <= '0; m_fevv <= 1'b0; m_ovr <= 1'b0;
                end
                1: if (sample_valid) begin
                    m_vec  <= {a, b, c};
                    m_due  <= cyc + S;
                    m_mode <= 2;
                end
                2: begin
                    if (sample_valid) m_ovr <= 1'b1;
                    if (cyc == m_due) begin
                        m_nvec <= m_nvec + 1;
                        m_cov  <= nc;
                        if (bad) begin
                            m_nerr <= m_nerr + 1;
                            if (!m_fevv) begin m_fev <= m_vec; m_fevv <= 1'b1; end
                        end
                        m_mode <= (nc == 8'hFF) ? 3 : 1;
                    end
                end
                default: m_mode <= 0;
            endcase
        end
    end

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin : compare
        logic eb, ed, ep;
        eb = (m_mode == 1) || (m_mode == 2);
        ed = (m_mode == 3);
        ep = ed && (m_nerr == 0);
        check("cycle_inst0",
              {busy0, done0, pass0, err0, vs0, cov0, fev0, fevv0, ovr0},
              {eb, ed, ep, 8'(imin(m_nerr, 255)), 4'(imin(m_nvec, 15)),
               m_cov, m_fev, m_fevv, m_ovr});
        check("cycle_inst1",
              {busy1, done1, pass1, err1, vs1, cov1, fev1, fevv1, ovr1},
              {eb, ed, ep, 2'(imin(m_nerr, 3)), 4'(imin(m_nvec, 15)),
               m_cov, m_fev, m_fevv, m_ovr});
    end

    // All tasks assume entry at a falling edge and return at a falling edge
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [2:0] v, input logic bad_s, input logic bad_c, input int gap);
        int s;
        s = int'(v[2]) + int'(v[1]) + int'(v[0]);
        sample_valid = 1'b1;
        {a, b, c}    = v;
        sum_in       = s[0] ^ bad_s;
        carry_in     = s[1] ^ bad_c;
        @(negedge clk);
        sample_valid = 1'b0;
        tick(gap - 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        tick(n);
        reset = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        reset = 1'b1; start = 1'b0; sample_valid = 1'b0;
        a = 1'b0; b = 1'b0; c = 1'b0; sum_in = 1'b0; carry_in = 1'b0;
        tick(3);
        reset = 1'b0;
        check("reset_state0", {busy0, done0, pass0, err0, vs0, cov0, fev0, fevv0, ovr0}, 64'd0);

        // 1: start together with a sample in idle, then all 8 correct vectors
        start = 1'b1; sample_valid = 1'b1; {a, b, c} = 3'b111;
        @(negedge clk);
        start = 1'b0; sample_valid = 1'b0;
        tick(3);
        check("t1_ignored_sample", {busy0, vs0}, {1'b1, 4'd0});
        for (int v = 0; v < 8; v++) begin
            send(3'(v), 1'b0, 1'b0, 4);
            if (v == 3) pulse_start(); // ignored while busy
        end
        check("t1_done_pass", {done0, pass0, busy0}, 3'b110);
        check("t1_counts", {err0, vs0, cov0, ovr0}, {8'd0, 4'd8, 8'hFF, 1'b0});

        // 2: Sum wrong at 011, Carry wrong at 110
        do_reset(2);
        pulse_start();
        for (int v = 0; v < 8; v++) send(3'(v), v == 3, v == 6, 4);
        check("t2_err", {done0, pass0, err0}, {1'b1, 1'b0, 8'd2});
        check("t2_first_err", {fevv0, fev0}, {1'b1, 3'b011});

        // 3: new run straight from done, with a duplicate vector
        pulse_start();
        check("t3_cleared", {busy0, done0, err0, fevv0, cov0}, {1'b1, 1'b0, 8'd0, 1'b0, 8'h00});
        send(3'd0, 1'b0, 1'b0, 4);
        for (int v = 0; v < 7; v++) send(3'(v), 1'b0, 1'b0, 4);
        check("t3_not_done", {done0, vs0, cov0}, {1'b0, 4'd8, 8'h7F});
        send(3'd7, 1'b0, 1'b0, 4);
        check("t3_done", {done0, pass0, vs0}, {1'b1, 1'b1, 4'd9});

        // 4: back-to-back samples and a Sum glitch before the sampling edge
        do_reset(2);
        pulse_start();
        sample_valid = 1'b1; {a, b, c} = 3'b101; sum_in = 1'b0; carry_in = 1'b1;
        @(negedge clk);
        {a, b, c} = 3'b010; sum_in = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0; sum_in = 1'b0;
        tick(3);
        check("t4_overrun", {ovr0, vs0, err0, cov0, busy0}, {1'b1, 4'd1, 8'd0, 8'h20, 1'b1});

        // 5: reset mid-run clears everything; samples ignored until start
        pulse_start();
        for (int v = 0; v < 4; v++) send(3'(v), 1'b1, 1'b0, 4);
        do_reset(1);
        check("t5_reset0", {busy0, done0, pass0, err0, vs0, cov0, fev0, fevv0, ovr0}, 64'd0);
        check("t5_reset1", {busy1, done1, pass1, err1, vs1, cov1, fev1, fevv1, ovr1}, 64'd0);
        send(3'b101, 1'b0, 1'b0, 4);
        check("t5_idle_ignore", {busy0, vs0, cov0}, {1'b0, 4'd0, 8'h00});

        // 6: 20 wrong samples over vectors 0..6, so coverage never completes
        pulse_start();
        for (int i = 0; i < 20; i++) send(3'(i % 7), 1'b1, 1'b0, 3);
        check("t6_sat1", {err1, vs1, done1, busy1}, {2'd3, 4'd15, 1'b0, 1'b1});
        check("t6_inst0", {err0, vs0, cov0}, {8'd20, 4'd15, 8'h7F});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/full_adder_checker.md
Name: full_adder_checker

Overview:
- Synthesizable response checker: the consuming end of the full-adder stimulus interface.
- Captures each applied vector (A, B, C) and the DUT's observed Sum/Carry after a settle delay.
- Compares the observed outputs against the golden result, counts mismatches and tracks coverage of all 8 input combinations.
- Sits beside any full_adder instance for self-checking benches and on-board BIST; reports pass/fail once coverage is complete.

Parameters:
- SETTLE_CYCLES, 2, cycles between vector capture and output sampling; legal range 1..15.
- ERR_CNT_W, 8, width of the saturating mismatch counter.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; arms a new checking run.
- sample_valid  input  1  one-cycle pulse; a new vector is present on Data_in_A/B/C.
- Data_in_A  input  1  applied operand A.
- Data_in_B  input  1  applied operand B.
- Data_in_C  input  1  applied carry-in.
- Data_in_Sum  input  1  observed DUT sum.
- Data_in_Carry  input  1  observed DUT carry-out.
- busy  output  1  high in ARMED and SETTLE.
- done  output  1  high in DONE.
- pass  output  1  done && error_count==0.
- error_count  output  ERR_CNT_W  mismatches in the current run; saturates at all-ones.
- vectors_seen  output  4  vectors checked in the current run; saturates at 15.
- coverage  output  8  bit i set once vector {A,B,C}==i has been checked.
- first_err_vec  output  3  {A,B,C} of the first mismatching vector.
- first_err_valid  output  1  first_err_vec holds a captured value.
- overrun  output  1  sticky; sample_valid arrived while in SETTLE.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs go to 0: busy, done, pass, error_count, vectors_seen, coverage, first_err_vec, first_err_valid, overrun.
  - Internal latch and settle counter clear.
  - Reset asserted mid-run aborts the run immediately, with no partial results retained.
- IDLE:
  - start -> ARMED.
  - On the same edge, clear error_count, vectors_seen, coverage, first_err_*, overrun.
  - sample_valid is ignored.
- ARMED: sample_valid at edge t:
  - Latch {A,B,C}.
  - Load settle counter with SETTLE_CYCLES-1.
  - Go to SETTLE.
- SETTLE:
  - Counter decrements each cycle.
  - At the edge where the counter is 0 (edge t+SETTLE_CYCLES), sample Data_in_Sum/Data_in_Carry and compare with exp_sum = A^B^C and exp_carry = (A&B)|(C&(A^B)), computed from the latched vector.
  - On that edge, vectors_seen += 1 (saturating) and coverage[{A,B,C}] is set.
  - On mismatch, error_count += 1 (saturating). If first_err_valid==0, capture first_err_vec and set first_err_valid.
  - Next state is DONE if the updated coverage == 8'hFF, else ARMED.
  - Results are visible on outputs from cycle t+SETTLE_CYCLES onward (registered).
- SETTLE, sample_valid asserted:
  - overrun is set (sticky); the new vector is dropped.
  - The in-flight check continues unaffected.
- Duplicate vectors: checked and counted normally; coverage is unchanged.
- DONE:
  - Results hold.
  - start -> ARMED with clear (new run); sample_valid ignored.
- start asserted while busy: ignored.
- start and sample_valid in the same cycle in IDLE: start is taken, the sample is ignored.
- pass is combinational from registered done and error_count; it is 0 whenever done=0.

Test Plan:
1. Reset, start, then 8 ordered vectors 000..111 with correct DUT outputs, sample_valid every 4 cycles -> done=1, pass=1, error_count=0, vectors_seen=8, coverage=8'hFF, overrun=0.
2. As scenario 1 but Data_in_Sum forced to 0 for vector 011, which is expected correct since sum 0 ... instead force Sum=1 at 011 and Carry=0 at 110 -> error_count=2, first_err_vec=3'b011, first_err_valid=1, pass=0.
3. Vectors 000,000,001,...,111 (9 samples, one duplicate) -> vectors_seen=9, done asserts only after 111 is checked, pass=1.
4. With SETTLE_CYCLES=2, pulse sample_valid on consecutive cycles -> overrun=1, second vector dropped, vectors_seen increments once; a Sum glitch at t+1 that is correct at t+2 yields no error.
5. Reset pulsed after 4 vectors -> all outputs 0, state IDLE; subsequent sample_valid is ignored until start.
6. ERR_CNT_W=2, 20 wrong samples cycling through non-covering vectors -> error_count saturates at 3 and vectors_seen saturates at 15, with done=0.
